// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, funct3 encodings and address-field widths for data_cache
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic int word_bits(input int words);
    return $clog2(words);
  endfunction

  function automatic int set_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int words);
    return 32 - 2 - $clog2(words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_store_align.sv
// rtl/dcache_store_align.sv - store lane/byte-enable alignment and load byte/half extraction
module dcache_store_align
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] lane;

  assign shamt = {offset, 3'b000};
  assign lane  = load_word >> shamt;

  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (funct3)
      F3_SB: begin
        be    = 4'b0001 << offset;
        wdata = {24'b0, store_data[7:0]} << shamt;
      end
      F3_SH: begin
        be    = 4'b0011 << offset;
        wdata = {16'b0, store_data[15:0]} << shamt;
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_data = load_word;
    case (funct3)
      F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  load_data = {24'b0, lane[7:0]};
      F3_LHU:  load_data = {16'b0, lane[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
// Optional DCACHE_STATS_EN adds saturating hit/miss/write-through counters.
module data_cache
  import dcache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  AddressingControlM,
  input  logic        FlushM,
  output logic [31:0] RDM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wt_count
`endif
);

  localparam int WB = word_bits(WORDS);
  localparam int SB = set_bits(SETS);
  localparam int TB = tag_bits(SETS, WORDS);

  state_e          state_q, state_d;
  logic [WB-1:0]   cnt_q, cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic [SETS-1:0] valid_q, valid_d;

  logic [TB-1:0]   tag_mem  [SETS];
  logic [31:0]     data_mem [SETS*WORDS];

  logic [WB-1:0]    widx;
  logic [SB-1:0]    set_idx;
  logic [TB-1:0]    tag;
  logic             hit;
  logic [31:0]      hit_word;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  logic             stall;
  logic             arr_we;
  logic [3:0]       arr_be;
  logic [31:0]      arr_wdata;
  logic [SB+WB-1:0] arr_idx;
  logic             tag_we;
  logic             load_hit;
  logic             refill_start;
  logic             store_done;

  assign widx     = ALUResultM[2 +: WB];
  assign set_idx  = ALUResultM[WB+2 +: SB];
  assign tag      = ALUResultM[31 -: TB];
  assign hit      = valid_q[set_idx] && (tag_mem[set_idx] == tag);
  assign hit_word = data_mem[{set_idx, widx}];

  dcache_store_align u_align (
    .funct3     (AddressingControlM),
    .offset     (ALUResultM[1:0]),
    .store_data (WriteDataM),
    .load_word  (hit_word),
    .be         (st_be),
    .wdata      (st_wdata),
    .load_data  (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    stall        = 1'b0;
    arr_we       = 1'b0;
    arr_be       = 4'b1111;
    arr_wdata    = mem_rdata;
    arr_idx      = {set_idx, widx};
    tag_we       = 1'b0;
    load_hit     = 1'b0;
    refill_start = 1'b0;
    store_done   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        flush_pend_d = 1'b0;
        if (MemReadM) begin
          if (hit) begin
            load_hit = 1'b1;
          end else begin
            stall        = 1'b1;
            state_d      = S_REFILL;
            cnt_d        = '0;
            refill_start = 1'b1;
          end
        end else if (MemWriteM) begin
          stall   = 1'b1;
          state_d = S_WRITE;
        end
        // A load hit this cycle still reads the pre-flush contents.
        if (FlushM || flush_pend_q) valid_d = '0;
      end
      S_REFILL: begin
        stall = 1'b1;
        if (FlushM) flush_pend_d = 1'b1;
        if (mem_ready) begin
          arr_we  = 1'b1;
          arr_idx = {set_idx, cnt_q};
          cnt_d   = cnt_q + WB'(1);
          if (cnt_q == WB'(WORDS - 1)) begin
            tag_we           = 1'b1;
            valid_d[set_idx] = 1'b1;
            state_d          = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        stall = ~mem_ready;
        if (FlushM) flush_pend_d = 1'b1;
        if (mem_ready) begin
          arr_we     = hit;
          arr_be     = st_be;
          arr_wdata  = st_wdata;
          state_d    = S_IDLE;
          store_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
    end
  end

  // Array writes are gated by state, which reset forces to IDLE asynchronously.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      for (int b = 0; b < 4; b++) begin
        if (arr_be[b]) data_mem[arr_idx][8*b +: 8] <= arr_wdata[8*b +: 8];
      end
    end
    if (tag_we) tag_mem[set_idx] <= tag;
  end

  always_comb begin
    mem_addr = '0;
    case (state_q)
      S_REFILL: mem_addr = {ALUResultM[31:WB+2], cnt_q, 2'b00};
      S_WRITE:  mem_addr = {ALUResultM[31:2], 2'b00};
      default:  mem_addr = '0;
    endcase
  end

  assign StallM    = stall;
  assign mem_req   = (state_q != S_IDLE);
  assign mem_we    = (state_q == S_WRITE);
  assign mem_be    = mem_we ? st_be : 4'b0000;
  assign mem_wdata = mem_we ? st_wdata : '0;
  assign RDM       = load_hit ? ld_data : '0;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wt_cnt_q, wt_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wt_cnt_d   = wt_cnt_q;
    if (load_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (refill_start && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    if (store_done && (wt_cnt_q != '1)) wt_cnt_d = wt_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wt_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wt_cnt_q   <= wt_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wt_count   = wt_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - scoreboard bench for data_cache with a backing RAM model
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic        FlushM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [2:0]  AddressingControlM = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] RDM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  data_cache #(.SETS(64), .WORDS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .MemReadM           (MemReadM),
    .MemWriteM          (MemWriteM),
    .ALUResultM         (ALUResultM),
    .WriteDataM         (WriteDataM),
    .AddressingControlM (AddressingControlM),
    .FlushM             (FlushM),
    .RDM                (RDM),
    .StallM             (StallM),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_be             (mem_be),
    .mem_rdata          (mem_rdata),
    .mem_ready          (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_load;
    logic [31:0] rdm;
    logic [3:0]  be;
    logic [31:0] wd;
    int          stalls;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    stall_cnt = 0;
  int    gap = 0;
  int    wait_cnt = 0;
  logic [31:0] ram [logic [31:0]];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 32'h0;
  endfunction

  // Backing RAM: decides ready shortly after each edge so it is stable by the next one.
  always @(posedge clk) begin
    logic [31:0] w;
    #2;
    if (rst && mem_req) begin
      if (wait_cnt >= gap) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        if (mem_we) begin
          w = ram_rd(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          ram[mem_addr] = w;
        end else begin
          mem_rdata = ram_rd(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      mem_rdata = '0;
    end
  end

  // Monitor: counts stall cycles of the current access and checks it when it completes.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (!rst) begin
      stall_cnt = 0;
    end else if (MemReadM || MemWriteM) begin
      if (StallM) begin
        stall_cnt++;
      end else begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_completion: access completed with empty scoreboard");
        end else begin
          e  = sb.pop_front();
          nm = sb_name.pop_front();
          chk({nm, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
          if (e.is_load) begin
            chk({nm, "_rdm"}, RDM, e.rdm);
          end else begin
            chk({nm, "_be"}, {28'b0, mem_be}, {28'b0, e.be});
            chk({nm, "_wdata"}, mem_wdata, e.wd);
          end
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic do_op(input string nm, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rdm, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input int exp_st, input bit fl);
    exp_t e;
    bit   done;
    done     = 1'b0;
    e.is_load = ld;
    e.rdm    = exp_rdm;
    e.be     = exp_be;
    e.wd     = exp_wd;
    e.stalls = exp_st;
    sb.push_back(e);
    sb_name.push_back(nm);
    @(posedge clk);
    #1;
    MemReadM           = ld;
    MemWriteM          = !ld;
    AddressingControlM = f3;
    ALUResultM         = a;
    WriteDataM         = wd;
    FlushM             = fl;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!StallM) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: StallM still 1 after 200 cycles, expected 0", nm);
      sb.delete();
      sb_name.delete();
    end
    @(posedge clk);
    #1;
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    FlushM    = 1'b0;
  endtask

  task automatic load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] exp_rdm, input int exp_st);
    do_op(nm, 1'b1, f3, a, 32'h0, exp_rdm, 4'h0, 32'h0, exp_st, 1'b0);
  endtask

  task automatic store(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_st);
    do_op(nm, 1'b0, f3, a, wd, 32'h0, exp_be, exp_wd, exp_st, 1'b0);
  endtask

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  initial begin
    int beats;
    ram[32'h100] = 32'hDEADBEEF;
    ram[32'h104] = 32'h11223344;
    ram[32'h108] = 32'h80A1B2C3;
    ram[32'h10C] = 32'h55667788;
    ram[32'h140] = 32'h0BADC0DE;
    ram[32'h180] = 32'hCAFEF00D;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {31'b0, StallM}, 32'h0);
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
    chk("reset_mem_be", {28'b0, mem_be}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rdm", RDM, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    gap = 0;
    load("cold_lw_100", LW, 32'h100, 32'hDEADBEEF, 5);
    load("hit_lw_104", LW, 32'h104, 32'h11223344, 0);
    load("lb_10b", LB, 32'h10B, 32'hFFFFFF80, 0);
    load("lbu_10b", LBU, 32'h10B, 32'h00000080, 0);
    load("lh_10a", LH, 32'h10A, 32'hFFFF80A1, 0);
    load("lhu_10a", LHU, 32'h10A, 32'h000080A1, 0);
    load("lb_108", LB, 32'h108, 32'hFFFFFFC3, 0);
    store("sh_102", SH, 32'h102, 32'h00001234, 4'b1100, 32'h12340000, 1);
    load("lw_100_merged", LW, 32'h100, 32'h1234BEEF, 0);
    store("sb_105", SB, 32'h105, 32'h00000077, 4'b0010, 32'h00007700, 1);
    load("lw_104_merged", LW, 32'h104, 32'h11227744, 0);
    store("sw_2000_uncached", SW, 32'h2000, 32'hA5A55A5A, 4'b1111, 32'hA5A55A5A, 1);
    load("lw_2000_miss", LW, 32'h2000, 32'hA5A55A5A, 5);

    gap = 2;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 FlushM = 1'b1;
        @(posedge clk);
        #1 FlushM = 1'b0;
      end
    join_none
    load("lw_180_flush_refill", LW, 32'h180, 32'hCAFEF00D, 13);
    gap = 0;
    load("lw_100_after_flush", LW, 32'h100, 32'h1234BEEF, 5);
    load("lw_180_after_flush", LW, 32'h180, 32'hCAFEF00D, 5);
    do_op("lw_180_hit_with_flush", 1'b1, LW, 32'h180, 32'h0, 32'hCAFEF00D, 4'h0, 32'h0, 0, 1'b1);
    load("lw_104_after_idle_flush", LW, 32'h104, 32'h11227744, 5);

    @(posedge clk);
    #1;
    MemReadM = 1'b1;
    AddressingControlM = LW;
    ALUResultM = 32'h140;
    beats = 0;
    for (int i = 0; i < 50 && beats < 3; i++) begin
      @(negedge clk);
      if (mem_ready) beats++;
    end
    chk("reset_test_beat2_reached", 32'(beats), 32'd3);
    #1;
    rst = 1'b0;
    MemReadM = 1'b0;
    #1;
    chk("midrefill_rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("midrefill_rst_stall", {31'b0, StallM}, 32'h0);
    chk("midrefill_rst_rdm", RDM, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    load("lw_140_after_rst", LW, 32'h140, 32'h0BADC0DE, 5);
    load("lw_100_after_rst", LW, 32'h100, 32'h1234BEEF, 5);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
